bs_unstuff: RTL and testbench

- Receive-path bit-unstuffing decoder for the USB controller.
- Takes the serial NRZI-decoded bitstream, one bit per cycle, and removes the stuffed 0 that follows every run of RUN_LEN consecutive 1s.
- Forwards the payload bits downstream to the PID/CRC checkers.
- Flags a bit-stuff violation and the end of each packet.
- Mirror of the transmit-side stuffer: the first IGNORE_BITS bits of each packet pass through uncounted.

---
 rtl/bs_unstuff.sv | 114 +++++++++++
 tb/tb_bs_unstuff.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bs_unstuff.sv
// Receive-side USB bit unstuffer: drops the 0 inserted after every RUN_LEN ones,
// reports stuffing violations and packet ends, and counts removed bits.
module bs_unstuff #(
  parameter int RUN_LEN     = 6,
  parameter int IGNORE_BITS = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       stuff_err,
  output logic       pkt_end,
  output logic [7:0] stuff_cnt
);

  localparam int OW = $clog2(RUN_LEN + 1);
  localparam int BW = (IGNORE_BITS < 1) ? 1 : $clog2(IGNORE_BITS + 1);
  localparam logic [OW-1:0] RUN_LAST = OW'(RUN_LEN);
  localparam logic [BW-1:0] IGN_LAST = BW'(IGNORE_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IGNORE = 3'd1,
    COUNT  = 3'd2,
    DROP   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [OW-1:0] ones_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      stuff_err <= 1'b0;
      pkt_end   <= 1'b0;
      stuff_cnt <= 8'd0;
    end else begin
      out_valid <= 1'b0;
      out_bit   <= in_valid & in_bit;
      stuff_err <= 1'b0;
      pkt_end   <= 1'b0;

      if (!in_valid) begin
        // Falling edge of in_valid closes any open packet.
        if (state != IDLE) begin
          pkt_end   <= 1'b1;
          stuff_err <= (state == DROP);
          state     <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            out_valid <= 1'b1;
            stuff_cnt <= 8'd0;
            bit_cnt   <= BW'(1);
            ones_cnt  <= '0;
            if (IGNORE_BITS == 0) begin
              ones_cnt <= in_bit ? OW'(1) : '0;
              state    <= (in_bit && RUN_LEN == 1) ? DROP : COUNT;
            end else if (IGNORE_BITS == 1) begin
              state <= COUNT;
            end else begin
              state <= IGNORE;
            end
          end

          IGNORE: begin
            out_valid <= 1'b1;
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt + BW'(1) == IGN_LAST) state <= COUNT;
          end

          COUNT: begin
            out_valid <= 1'b1;
            if (in_bit) begin
              ones_cnt <= ones_cnt + OW'(1);
              if (ones_cnt + OW'(1) == RUN_LAST) state <= DROP;
            end else begin
              ones_cnt <= '0;
            end
          end

          DROP: begin
            if (!in_bit) begin
              stuff_cnt <= sat_inc8(stuff_cnt);
              ones_cnt  <= '0;
              state     <= COUNT;
            end else begin
              stuff_err <= 1'b1;
              state     <= ERROR;
            end
          end

          ERROR: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bs_unstuff.sv
// Scoreboard bench for bs_unstuff: a bit-position reference model queues the
// expected outputs of every driven cycle; a monitor compares one cycle later.
module tb_bs_unstuff;

  localparam int RUN = 6;
  localparam int IGN = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic       out_bit;
  logic       stuff_err;
  logic       pkt_end;
  logic [7:0] stuff_cnt;

  bs_unstuff #(.RUN_LEN(RUN), .IGNORE_BITS(IGN)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .stuff_err (stuff_err),
    .pkt_end   (pkt_end),
    .stuff_cnt (stuff_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ov;
    logic       ob;
    logic       se;
    logic       pe;
    logic [7:0] sc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: position in packet, current run of counted ones,
  // mode 0 = normal, 1 = next bit must be a stuffed 0, 2 = violation seen.
  int m_active = 0;
  int m_pos    = 0;
  int m_run    = 0;
  int m_mode   = 0;
  int m_scnt   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic b);
    exp_t e;
    @(negedge clock);
    reset    = r;
    in_valid = v;
    in_bit   = b;
    e = '0;
    if (r) begin
      m_active = 0;
      m_mode   = 0;
      m_run    = 0;
      m_scnt   = 0;
    end else if (v) begin
      if (m_active == 0) begin
        m_active = 1;
        m_pos    = 0;
        m_run    = 0;
        m_mode   = 0;
        m_scnt   = 0;
      end
      if (m_mode == 1) begin
        if (!b) begin
          m_scnt = (m_scnt < 255) ? m_scnt + 1 : 255;
          m_run  = 0;
          m_mode = 0;
        end else begin
          e.se   = 1'b1;
          m_mode = 2;
        end
      end else if (m_mode == 0) begin
        e.ov = 1'b1;
        e.ob = b;
        if (m_pos >= IGN) begin
          if (b) begin
            m_run++;
            if (m_run == RUN) m_mode = 1;
          end else begin
            m_run = 0;
          end
        end
      end
      m_pos++;
    end else if (m_active != 0) begin
      e.pe = 1'b1;
      e.se = (m_mode == 1);
      m_active = 0;
    end
    e.sc = m_scnt[7:0];
    q.push_back(e);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s.getc(i) == 8'h31);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  always begin
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      check_eq("out_valid", int'(out_valid), int'(e_mon.ov));
      if (e_mon.ov) check_eq("out_bit", int'(out_bit), int'(e_mon.ob));
      check_eq("stuff_err", int'(stuff_err), int'(e_mon.se));
      check_eq("pkt_end", int'(pkt_end), int'(e_mon.pe));
      check_eq("stuff_cnt", int'(stuff_cnt), int'(e_mon.sc));
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    gap();

    // Clean packet: 0x3C then 0xA5, each LSB first.
    send_str("0011110010100101");
    gap();

    // Single stuffed zero after the ignore window.
    send_str("0101010");
    send_str("11111101010");
    gap();

    // Leading ones are uncounted; then two stuffed zeros.
    send_str("11111110");
    send_str("1111110111111001");
    gap();

    // Violation: seven counted ones, tail dropped until in_valid falls.
    send_str("0000000");
    send_str("11111110101");
    gap();

    // Truncated run: packet ends while a stuffed zero is expected.
    send_str("0000000");
    send_str("111111");
    gap();

    // Reset while expecting a stuffed bit, then an immediate new packet.
    send_str("0000000");
    send_str("111111");
    drive(1'b1, 1'b1, 1'b0);
    send_str("1010101");
    send_str("111111000110");
    gap();

    // Random packets with single-cycle gaps.
    for (int p = 0; p < 6; p++) begin
      int len;
      len = $urandom_range(8, 40);
      for (int i = 0; i < len; i++) drive(1'b0, 1'b1, ($urandom_range(0, 3) != 0));
      gap();
    end

    // Saturation of stuff_cnt at 255.
    send_str("0000000");
    for (int k = 0; k < 260; k++) send_str("1111110");
    send_str("01");
    gap();
    gap();

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    @(posedge clock);
    @(posedge clock);
    #2;
    check_eq("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
